// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: data width, opcodes, FSM states.
package alu_pkg;

  localparam int DATA_W = 4;

  localparam logic [DATA_W-1:0] OP_ADD = 4'd0;
  localparam logic [DATA_W-1:0] OP_SUB = 4'd1;
  localparam logic [DATA_W-1:0] OP_MUL = 4'd2;
  localparam logic [DATA_W-1:0] OP_DIV = 4'd3;
  localparam logic [DATA_W-1:0] OP_AND = 4'd4;
  localparam logic [DATA_W-1:0] OP_OR  = 4'd5;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    SHOW   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Operand/result bus between the sequencer (master) and the registered ALU (slave).
interface alu_operand_sequencer_if;
  import alu_pkg::*;

  logic              alu_reset;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              carry_flag;

  modport master (output alu_reset, data_a, data_b, alu_sel,
                  input  alu_out, carry_flag);
  modport slave  (input  alu_reset, data_a, data_b, alu_sel,
                  output alu_out, carry_flag);
endinterface

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector; the pulse is high for the first cycle d_i is seen high.
module edge_detect_rise (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic pulse_o
);
  logic d_q;

  always_ff @(posedge clk) begin
    if (!reset_n) d_q <= 1'b0;
    else          d_q <= d_i;
  end

  assign pulse_o = d_i & ~d_q;
endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode from switches, issues them to the ALU and holds the result.
// Optional macro DIV_ZERO_CHECK_EN: divide by zero short-circuits to SHOW with err=1.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_W-1:0]             sw_value,
  input  logic                          btn_enter,
  input  logic                          btn_clear,
  alu_operand_sequencer_if.master       alu,
  output logic [DATA_W-1:0]             result,
  output logic                          result_carry,
  output logic                          result_valid,
  output logic [2:0]                    stage,
  output logic                          err
);
  localparam logic [2:0] WAIT_INIT = 3'(ALU_LATENCY - 1);

  logic              enter_pulse;
  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sel_q, sel_d, res_q, res_d;
  logic              carry_q, carry_d, err_q, err_d;
  logic [2:0]        cnt_q, cnt_d;

  edge_detect_rise u_enter_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (btn_enter),
    .pulse_o (enter_pulse)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    carry_d = carry_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    // Clear overrides everything but keeps the last captured result on display.
    if (btn_clear) begin
      state_d = GET_A;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        GET_A: if (enter_pulse) begin a_d = sw_value; state_d = GET_B; end
        GET_B: if (enter_pulse) begin b_d = sw_value; state_d = GET_OP; end
        GET_OP: if (enter_pulse) begin
          sel_d   = sw_value;
          state_d = ISSUE;
`ifdef DIV_ZERO_CHECK_EN
          if (sw_value == OP_DIV && b_q == '0) begin
            state_d = SHOW;
            err_d   = 1'b1;
            res_d   = '0;
            carry_d = 1'b0;
          end
`endif
        end
        ISSUE: begin
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            res_d   = alu.alu_out;
            carry_d = alu.carry_flag;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        SHOW: if (enter_pulse) begin state_d = GET_A; err_d = 1'b0; end
        default: state_d = GET_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu.alu_reset = ~reset_n;
  assign alu.data_a    = a_q;
  assign alu.data_b    = b_q;
  assign alu.alu_sel   = sel_q;
  assign result        = res_q;
  assign result_carry  = carry_q;
  assign result_valid  = (state_q == SHOW);
  assign stage         = state_q;
  assign err           = err_q;
endmodule
